argmax_feeder: RTL and testbench

ARGMAX_FEEDER -- requirements
Module: argmax_feeder

---
 rtl/argmax_pkg.sv | 13 +
 rtl/argmax_feeder.sv | 119 +++++++++++
 tb/tb_argmax_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax datapath: the feeder's FSM encoding and
// the default vector geometry used by both the feeder and the argmax cell.
package argmax_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_CELL_AMOUNT = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/argmax_feeder.sv
// Serialises packed vectors into (index, value) pairs for the argmax cell.
// An active register streams one element per cycle; a one-deep pending register absorbs the next vector.
module argmax_feeder
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CELL_AMOUNT = DEFAULT_CELL_AMOUNT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CELL_AMOUNT*DATA_WIDTH-1:0] in_values,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             output_index,
  output logic [DATA_WIDTH-1:0]             output_value,
  output logic                              output_enable,
  output logic                              busy,
  output fsm_state_t                        fsm_state
);

  localparam int VEC_WIDTH = CELL_AMOUNT * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] LAST_INDEX = DATA_WIDTH'(CELL_AMOUNT - 1);

  // Handshake: a vector is taken on a rising edge where in_valid && in_ready.
  // in_ready is a register (not pending_full), so it never depends on in_valid.

  fsm_state_t            state, state_n;
  logic [DATA_WIDTH-1:0] cnt, cnt_n;
  logic [VEC_WIDTH-1:0]  active, active_n;
  logic [VEC_WIDTH-1:0]  pending, pending_n;
  logic                  pending_full, pending_full_n;
  logic                  in_ready_n;
  logic [DATA_WIDTH-1:0] index_n, value_n;
  logic                  enable_n;
  logic [DATA_WIDTH-1:0] cur_value;
  logic                  accept;

  assign accept    = in_valid && in_ready;
  assign busy      = (state == STREAM) || pending_full;
  assign fsm_state = state;

  always_comb begin
    cur_value = '0;
    for (int i = 0; i < CELL_AMOUNT; i++) begin
      if (cnt == DATA_WIDTH'(i)) cur_value = active[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    active_n       = active;
    pending_n      = pending;
    pending_full_n = pending_full;
    index_n        = '0;
    value_n        = '0;
    enable_n       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          active_n = in_values;
          cnt_n    = '0;
          state_n  = STREAM;
        end
      end
      STREAM: begin
        index_n  = cnt;
        value_n  = cur_value;
        enable_n = 1'b1;
        if (cnt != LAST_INDEX) begin
          cnt_n = cnt + DATA_WIDTH'(1);
          if (accept) begin
            pending_n      = in_values;
            pending_full_n = 1'b1;
          end
        end else if (pending_full) begin
          // Hand the skid vector straight over so streams chain without a bubble.
          active_n       = pending;
          pending_n      = '0;
          pending_full_n = 1'b0;
          cnt_n          = '0;
        end else if (accept) begin
          active_n = in_values;
          cnt_n    = '0;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    in_ready_n = !pending_full_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_full  <= 1'b0;
      in_ready      <= 1'b1;
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      active        <= active_n;
      pending       <= pending_n;
      pending_full  <= pending_full_n;
      in_ready      <= in_ready_n;
      output_index  <= index_n;
      output_value  <= value_n;
      output_enable <= enable_n;
    end
  end

endmodule

// File: tb/tb_argmax_feeder.sv
// Directed bench for argmax_feeder at DATA_WIDTH=8, CELL_AMOUNT=4, with a
// reference argmax (later index wins ties) computed over the emitted stream.
module tb_argmax_feeder;
  import argmax_pkg::*;

  localparam int DW = 8;
  localparam int CA = 4;

  logic             clk;
  logic             rst_n;
  logic [CA*DW-1:0] in_values;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    output_index;
  logic [DW-1:0]    output_value;
  logic             output_enable;
  logic             busy;
  fsm_state_t       fsm_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] best_val;
  logic [DW-1:0] best_idx;

  argmax_feeder #(.DATA_WIDTH(DW), .CELL_AMOUNT(CA)) dut (
    .clk(clk), .rst_n(rst_n), .in_values(in_values), .in_valid(in_valid),
    .in_ready(in_ready), .output_index(output_index), .output_value(output_value),
    .output_enable(output_enable), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CA*DW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic offer(input logic [CA*DW-1:0] vec);
    in_values = vec;
    in_valid  = 1'b1;
  endtask

  task automatic withdraw();
    in_valid  = 1'b0;
    in_values = '0;
  endtask

  task automatic expect_emit(input int idx, input int val);
    check("enable", {31'd0, output_enable}, 32'd1);
    check("index", {24'd0, output_index}, idx);
    check("value", {24'd0, output_value}, val);
    if (idx == 0 || output_value >= best_val) begin
      best_val = output_value;
      best_idx = output_index;
    end
  endtask

  task automatic expect_idle_outputs(input string tag);
    check({tag, "_enable"}, {31'd0, output_enable}, 32'd0);
    check({tag, "_index"}, {24'd0, output_index}, 32'd0);
    check({tag, "_value"}, {24'd0, output_value}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_values = '0;
    best_val  = '0;
    best_idx  = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_idle_outputs("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single vector {3,9,9,1}
    offer(pack4(3, 9, 9, 1));
    tick();
    check("accept_no_enable", {31'd0, output_enable}, 32'd0);
    check("accept_busy", {31'd0, busy}, 32'd1);
    withdraw();
    tick(); expect_emit(0, 3);
    tick(); expect_emit(1, 9);
    tick(); expect_emit(2, 9);
    tick(); expect_emit(3, 1);
    check("argmax_single", {24'd0, best_idx}, 32'd2);
    tick();
    expect_idle_outputs("after_single");
    check("after_single_busy", {31'd0, busy}, 32'd0);

    // A, B back-to-back, C offered while B is pending
    offer(pack4(1, 2, 3, 4));
    tick();
    offer(pack4(8, 7, 6, 5));
    tick(); expect_emit(0, 1);
    check("b_pending_ready", {31'd0, in_ready}, 32'd0);
    offer(pack4(4, 2, 6, 6));
    tick(); expect_emit(1, 2);
    check("c_blocked_ready", {31'd0, in_ready}, 32'd0);
    tick(); expect_emit(2, 3);
    check("c_blocked_busy", {31'd0, busy}, 32'd1);
    tick(); expect_emit(3, 4);
    check("argmax_a", {24'd0, best_idx}, 32'd3);
    check("ready_after_handover", {31'd0, in_ready}, 32'd1);
    tick(); expect_emit(0, 8);
    check("c_pending_ready", {31'd0, in_ready}, 32'd0);
    withdraw();
    tick(); expect_emit(1, 7);
    tick(); expect_emit(2, 6);
    tick(); expect_emit(3, 5);
    check("argmax_b", {24'd0, best_idx}, 32'd0);
    check("ready_after_c", {31'd0, in_ready}, 32'd1);
    tick(); expect_emit(0, 4);
    tick(); expect_emit(1, 2);
    tick(); expect_emit(2, 6);
    tick(); expect_emit(3, 6);
    check("argmax_c", {24'd0, best_idx}, 32'd3);
    tick();
    expect_idle_outputs("after_abc");

    // acceptance on the last-index edge with pending empty
    offer(pack4(7, 1, 1, 1));
    tick();
    withdraw();
    tick(); expect_emit(0, 7);
    tick(); expect_emit(1, 1);
    tick(); expect_emit(2, 1);
    offer(pack4(2, 2, 9, 2));
    tick(); expect_emit(3, 1);
    check("argmax_d", {24'd0, best_idx}, 32'd0);
    check("direct_ready", {31'd0, in_ready}, 32'd1);
    withdraw();
    tick(); expect_emit(0, 2);
    tick(); expect_emit(1, 2);
    tick(); expect_emit(2, 9);
    tick(); expect_emit(3, 2);
    check("argmax_e", {24'd0, best_idx}, 32'd2);
    tick();
    expect_idle_outputs("after_de");

    // reset while index 2 is on the outputs
    offer(pack4(1, 2, 3, 4));
    tick();
    withdraw();
    tick(); expect_emit(0, 1);
    tick(); expect_emit(1, 2);
    tick(); expect_emit(2, 3);
    #1 rst_n = 1'b0;
    #1;
    expect_idle_outputs("midreset");
    check("midreset_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    offer(pack4(5, 5, 5, 5));
    tick();
    check("post_reset_accept", {31'd0, output_enable}, 32'd0);
    withdraw();
    tick(); expect_emit(0, 5);
    tick(); expect_emit(1, 5);
    tick(); expect_emit(2, 5);
    tick(); expect_emit(3, 5);
    check("argmax_f", {24'd0, best_idx}, 32'd3);
    tick();
    expect_idle_outputs("final");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
